// File: rtl/text_buffer_controller.sv
// Port-A sequencer for the GPU text buffer: arbitrates CPU accesses against a clear/scroll fill engine.
// Build option: define TEXT_SCROLL_EN to include the hardware scroll-up engine.
module text_buffer_controller #(
  parameter int         COLUMNS    = 80,
  parameter int         ROWS       = 30,
  parameter int         ADDR_WIDTH = $clog2(COLUMNS*ROWS),
  parameter logic [7:0] FILL_CHAR  = 8'h20
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cpu_request,
  input  logic                  cpu_write_enable,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [7:0]            cpu_data_in,
  output logic                  cpu_ack,
  output logic [7:0]            cpu_data_out,
  input  logic                  cmd_clear,
  input  logic                  cmd_scroll,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [7:0]            ram_data_in,
  output logic                  ram_write_enable,
  input  logic [7:0]            ram_data_out
);

  localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(COLUMNS*ROWS-1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
`ifdef TEXT_SCROLL_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_MOVE  = ADDR_WIDTH'((ROWS-1)*COLUMNS-1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(COLUMNS);
`endif

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CPU_ISSUE = 3'd1,
    CPU_WAIT  = 3'd2,
    CPU_ACK   = 3'd3,
    CLR_WRITE = 3'd4
`ifdef TEXT_SCROLL_EN
    ,
    SCR_READ  = 3'd5,
    SCR_WAIT  = 3'd6,
    SCR_WRITE = 3'd7
`endif
  } state_t;

  state_t                  state_r, state_s;
  state_t                  resume_r, resume_s;
  state_t                  eng_s;
  logic [ADDR_WIDTH-1:0]   cell_r, cell_s;
  logic                    busy_r, busy_s;
  logic [ADDR_WIDTH-1:0]   ram_address_r, ram_address_s;
  logic [7:0]              ram_data_in_r, ram_data_in_s;
  logic                    ram_we_r, ram_we_s;
  logic                    cpu_ack_r, cpu_ack_s;
  logic [7:0]              cpu_data_out_r, cpu_data_out_s;
`ifdef TEXT_SCROLL_EN
  logic [ADDR_WIDTH-1:0]   src_r, src_s;
`else
  logic                    unused_scroll_s;
  assign unused_scroll_s = cmd_scroll;
`endif

  // Next-state, counter and registered-output values; outputs are computed for the state being entered.
  always_comb begin
    state_s        = state_r;
    resume_s       = resume_r;
    eng_s          = CLR_WRITE;
    cell_s         = cell_r;
    busy_s         = busy_r;
    ram_address_s  = ram_address_r;
    ram_data_in_s  = ram_data_in_r;
    ram_we_s       = 1'b0;
    cpu_ack_s      = 1'b0;
    cpu_data_out_s = cpu_data_out_r;
`ifdef TEXT_SCROLL_EN
    src_s          = src_r;
`endif

    case (state_r)
      IDLE: begin
        if (cmd_clear) begin
          busy_s  = 1'b1;
          cell_s  = '0;
          state_s = CLR_WRITE;
        end
`ifdef TEXT_SCROLL_EN
        else if (cmd_scroll) begin
          busy_s  = 1'b1;
          cell_s  = '0;
          src_s   = ROW_STRIDE;
          state_s = SCR_READ;
        end
`endif
        else if (cpu_request) begin
          resume_s = IDLE;
          state_s  = CPU_ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      CPU_ISSUE: state_s = CPU_WAIT;
      CPU_WAIT:  state_s = CPU_ACK;
      CPU_ACK:   state_s = resume_r;
      CLR_WRITE: begin
        if (cell_r == LAST_CELL) begin
          busy_s  = 1'b0;
          state_s = IDLE;
        end else begin
          // A pending CPU request gets one slot between engine cells.
          cell_s   = cell_r + ADDR_ONE;
          eng_s    = CLR_WRITE;
          resume_s = eng_s;
          state_s  = cpu_request ? CPU_ISSUE : eng_s;
        end
      end
`ifdef TEXT_SCROLL_EN
      SCR_READ: state_s = SCR_WAIT;
      SCR_WAIT: state_s = SCR_WRITE;
      SCR_WRITE: begin
        cell_s   = cell_r + ADDR_ONE;
        src_s    = src_r + ADDR_ONE;
        eng_s    = (cell_r == LAST_MOVE) ? CLR_WRITE : SCR_READ;
        resume_s = eng_s;
        state_s  = cpu_request ? CPU_ISSUE : eng_s;
      end
`endif
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase

    case (state_s)
      CPU_ISSUE: begin
        ram_address_s = cpu_address;
        ram_data_in_s = cpu_data_in;
        ram_we_s      = cpu_write_enable;
      end
      CPU_ACK: begin
        cpu_ack_s      = 1'b1;
        cpu_data_out_s = ram_data_out;
      end
      CLR_WRITE: begin
        ram_address_s = cell_s;
        ram_data_in_s = FILL_CHAR;
        ram_we_s      = 1'b1;
      end
`ifdef TEXT_SCROLL_EN
      SCR_READ: begin
        ram_address_s = src_s;
      end
      SCR_WRITE: begin
        // Source byte arrives from the registered RAM read during SCR_WAIT.
        ram_address_s = cell_r;
        ram_data_in_s = ram_data_out;
        ram_we_s      = 1'b1;
      end
`endif
      default: begin
        ram_we_s = 1'b0;
      end
    endcase
  end

  // State, counters and all outputs registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      resume_r       <= IDLE;
      cell_r         <= '0;
      busy_r         <= 1'b0;
      ram_address_r  <= '0;
      ram_data_in_r  <= 8'h00;
      ram_we_r       <= 1'b0;
      cpu_ack_r      <= 1'b0;
      cpu_data_out_r <= 8'h00;
`ifdef TEXT_SCROLL_EN
      src_r          <= '0;
`endif
    end else begin
      state_r        <= state_s;
      resume_r       <= resume_s;
      cell_r         <= cell_s;
      busy_r         <= busy_s;
      ram_address_r  <= ram_address_s;
      ram_data_in_r  <= ram_data_in_s;
      ram_we_r       <= ram_we_s;
      cpu_ack_r      <= cpu_ack_s;
      cpu_data_out_r <= cpu_data_out_s;
`ifdef TEXT_SCROLL_EN
      src_r          <= src_s;
`endif
    end
  end

  assign ram_address      = ram_address_r;
  assign ram_data_in      = ram_data_in_r;
  assign ram_write_enable = ram_we_r;
  assign cpu_ack          = cpu_ack_r;
  assign cpu_data_out     = cpu_data_out_r;
  assign busy             = busy_r;

endmodule

// File: doc/text_buffer_controller.md
# text_buffer_controller

Sequencer and arbiter for port A of the GPU text buffer RAM. Shares the single read/write port between a CPU-side requester and an internal fill/scroll engine that clears the screen or scrolls it up one row in hardware. Sits between the bus interface and the text buffer; port B (video scan-out) is untouched.

## Interface

- COLUMNS, 80, characters per row
- ROWS, 30, rows on screen; COLUMNS*ROWS equals `GPU_TEXT_BUFFER_LENGTH
- ADDR_WIDTH, $clog2(COLUMNS*ROWS), RAM address width
- FILL_CHAR, 8'h20, byte written by clear and into the vacated bottom row

- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_request  in  1  requester holds high with address/data/we stable until cpu_ack
- cpu_write_enable  in  1  1 = write, 0 = read
- cpu_address  in  ADDR_WIDTH  cell address
- cpu_data_in  in  8  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_data_out  out  8  read data, valid while cpu_ack=1
- cmd_clear  in  1  one-cycle pulse: fill whole buffer with FILL_CHAR
- cmd_scroll  in  1  one-cycle pulse: scroll up one row
- busy  out  1  engine operation in progress
- ram_address  out  ADDR_WIDTH  to RAM port A address
- ram_data_in  out  8  to RAM port A write data
- ram_write_enable  out  1  to RAM port A write enable
- ram_data_out  in  8  from RAM port A (registered, 1-cycle read latency)

## Operation

- All outputs registered. Reset values: ram_address 0, ram_data_in 0, ram_write_enable 0, cpu_ack 0, cpu_data_out 0, busy 0; state IDLE.
- States: IDLE, CPU_ISSUE, CPU_WAIT, CPU_ACK, CLR_WRITE, SCR_READ, SCR_WAIT, SCR_WRITE.
- IDLE: priority cmd_clear > cmd_scroll > cpu_request. Command → load counter, busy=1, go CLR_WRITE (clear: addr 0) or SCR_READ (dst 0). Else cpu_request → CPU_ISSUE.
- CPU path: CPU_ISSUE drives ram_address=cpu_address, ram_write_enable=cpu_write_enable, ram_data_in=cpu_data_in; CPU_WAIT deasserts write enable; CPU_ACK captures ram_data_out into cpu_data_out, cpu_ack=1; returns to IDLE or resumes engine. cpu_request is ignored during CPU_ACK.
- Clear: CLR_WRITE writes FILL_CHAR to one address per cycle, 0..COLUMNS*ROWS-1.
- Scroll: for dst 0..(ROWS-1)*COLUMNS-1: SCR_READ issues read of dst+COLUMNS, SCR_WAIT, SCR_WRITE writes captured byte to dst. Then CLR_WRITE over (ROWS-1)*COLUMNS..COLUMNS*ROWS-1.
- Fairness: after every engine write cycle, if cpu_request=1 one CPU access (3 cycles) is served, then engine resumes at next cell. Engine never starves CPU; CPU never starves engine.
- cmd_clear/cmd_scroll while busy=1: ignored, not queued. Both in same cycle: clear only.
- Address counters sized ADDR_WIDTH; no wrap beyond COLUMNS*ROWS-1.
- Reset mid-operation: immediate return to reset values; buffer contents left partially updated; no resume.

## Timing

- CPU access: request sampled at edge E0 (IDLE) → RAM access at E1 → cpu_ack high for cycle after E2. Latency 3 cycles, plus at most 3 cycles if engine mid-cell.
- busy rises at edge accepting the command; falls at the edge after the final write cycle.
- Clear duration: COLUMNS*ROWS cycles (2400 default). Scroll: 3*(ROWS-1)*COLUMNS + COLUMNS cycles (7040 default), each excluding interleaved CPU slots.
- Read-after-write to same address within the CPU path returns the new byte.

## Configuration

- TEXT_SCROLL_EN defined: scroll engine (SCR_* states, source counter) compiled in.
- Undefined: cmd_scroll ignored entirely; SCR_* states absent; clear and CPU paths unchanged.

## Test plan

- Reset then CPU write 8'h41 to addr 5, read addr 5 → cpu_ack 3 cycles after each request; read returns 8'h41.
- cmd_clear pulse → busy high 2400 cycles; every cell reads 8'h20; busy falls exactly once.
- Preload row r with byte r, cmd_scroll → row r holds r+1 for r<29, row 29 all 8'h20, 7040 busy cycles (TEXT_SCROLL_EN).
- cpu_request held continuously during scroll → CPU and engine alternate; every CPU ack ≤6 cycles after request; scroll result still correct.
- cmd_clear and cmd_scroll same cycle; cmd_scroll again while busy → only clear performed, second command dropped.
- reset_n low mid-scroll → all outputs zero immediately; next CPU read served normally; without TEXT_SCROLL_EN cmd_scroll leaves busy=0.
